// File: rtl/gate_resp_checker.sv
// -----------------------------------------------------------------------------
// gate_resp_checker
//
// Receiving end of a 2-input gate stimulus/monitor flow. A source streams
// {a, b, o} samples over a valid/ready handshake; each observed o is compared
// against a 4-entry truth table latched at the start of a run. The checker
// counts vectors and mismatches, records which input indices were exercised,
// captures the first failing vector and produces a pass/fail verdict.
//
// Parameters
//   NUM_VEC    accepted vectors that end a run automatically (>= 1)
//   CNT_W      width of vec_cnt / err_cnt (2^CNT_W-1 >= NUM_VEC)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      pulse: begin a run (IDLE/DONE), latches truth_tbl
//   stop       pulse: end a run early (RUN only, wins over start)
//   truth_tbl  expected o for index {a,b}; bit i -> index i
//   in_valid   sample valid
//   in_a/in_b  gate inputs of the sample
//   in_o       observed gate output of the sample
//   in_ready   checker accepts samples (RUN only)
//   done       run finished, results stable
//   pass       verdict, meaningful while done = 1
//   vec_cnt    accepted samples
//   err_cnt    mismatching samples, saturating
//   coverage   bit i set once index i has been accepted
//   fail_valid first mismatch captured
//   fail_idx   {a,b} of the first mismatch
//   fail_o     observed o of the first mismatch
// -----------------------------------------------------------------------------
module gate_resp_checker #(
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       truth_tbl,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_o,
  output logic             in_ready,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       coverage,
  output logic             fail_valid,
  output logic [1:0]       fail_idx,
  output logic             fail_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // vec_cnt value held just before the final accept of a run
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       tbl_q, tbl_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_idx_q, fail_idx_d;
  logic             fail_o_q, fail_o_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             ready_q, ready_d;

  logic             accept_s;
  logic [1:0]       idx_s;
  logic             mismatch_s;
  logic             last_s;

  // Handshake decode and per-sample comparison against the latched table
  always_comb begin
    idx_s      = {in_a, in_b};
    accept_s   = in_valid && ready_q;
    mismatch_s = (in_o != tbl_q[idx_s]);
    last_s     = accept_s && (vec_q == LAST_CNT);
  end

  // Next-state and result-update logic
  always_comb begin
    state_d      = state_q;
    tbl_d        = tbl_q;
    vec_d        = vec_q;
    err_d        = err_q;
    cov_d        = cov_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    fail_o_d     = fail_o_q;
    done_d       = done_q;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          tbl_d        = truth_tbl;
          vec_d        = '0;
          err_d        = '0;
          cov_d        = 4'h0;
          fail_valid_d = 1'b0;
          fail_idx_d   = 2'b00;
          fail_o_d     = 1'b0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        if (accept_s) begin
          vec_d        = vec_q + CNT_ONE;
          cov_d[idx_s] = 1'b1;
          if (mismatch_s) begin
            if (err_q != CNT_MAX) begin
              err_d = err_q + CNT_ONE;
            end else begin
              err_d = err_q;
            end
            // only the first mismatch of a run is recorded
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_idx_d   = idx_s;
              fail_o_d     = in_o;
            end else begin
              fail_valid_d = fail_valid_q;
            end
          end else begin
            err_d = err_q;
          end
        end else begin
          vec_d = vec_q;
        end

        // verdict uses the post-accept values so a same-cycle sample counts
        if (stop || last_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0) && (cov_d == 4'hF);
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        tbl_d        = 4'h0;
        vec_d        = '0;
        err_d        = '0;
        cov_d        = 4'h0;
        fail_valid_d = 1'b0;
        fail_idx_d   = 2'b00;
        fail_o_d     = 1'b0;
        done_d       = 1'b0;
        pass_d       = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_RUN);
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tbl_q        <= 4'h0;
      vec_q        <= '0;
      err_q        <= '0;
      cov_q        <= 4'h0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= 2'b00;
      fail_o_q     <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tbl_q        <= tbl_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      cov_q        <= cov_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      fail_o_q     <= fail_o_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign vec_cnt    = vec_q;
  assign err_cnt    = err_q;
  assign coverage   = cov_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign fail_o     = fail_o_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_resp_checker
//
// Directed bench for gate_resp_checker with NUM_VEC = 16, CNT_W = 16.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_gate_resp_checker;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [3:0]       truth_tbl;
  logic             in_valid;
  logic             in_a;
  logic             in_b;
  logic             in_o;
  logic             in_ready;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       coverage;
  logic             fail_valid;
  logic [1:0]       fail_idx;
  logic             fail_o;

  int checks;
  int errors;

  gate_resp_checker #(.NUM_VEC(16), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .truth_tbl  (truth_tbl),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_o       (in_o),
    .in_ready   (in_ready),
    .done       (done),
    .pass       (pass),
    .vec_cnt    (vec_cnt),
    .err_cnt    (err_cnt),
    .coverage   (coverage),
    .fail_valid (fail_valid),
    .fail_idx   (fail_idx),
    .fail_o     (fail_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one sample for exactly one edge, then drop valid
  task automatic send(input logic a, input logic b, input logic o);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_o     = o;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] tbl);
    truth_tbl = tbl;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, done, pass, fail_valid, fail_idx, fail_o} !== 7'b0) begin
      $display("FAIL reset_flags: got %b, want 0000000",
               {in_ready, done, pass, fail_valid, fail_idx, fail_o});
      errors++;
    end
    checks++;
    if (vec_cnt !== 16'd0 || err_cnt !== 16'd0 || coverage !== 4'h0) begin
      $display("FAIL reset_counts: vec=%0d err=%0d cov=%h, want 0 0 0",
               vec_cnt, err_cnt, coverage);
      errors++;
    end
  endtask

  task automatic test_or_pass();
    pulse_start(4'hE);
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL start_ready: in_ready=%b, want 1", in_ready);
      errors++;
    end
    in_valid = 1'b1;
    for (int v = 0; v < 16; v++) begin
      {in_a, in_b} = v[1:0];
      in_o         = v[1] | v[0];
      tick();
      if (v == 14) begin
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || vec_cnt !== 16'd15) begin
          $display("FAIL or_15th: done=%b ready=%b vec=%0d, want 0 1 15",
                   done, in_ready, vec_cnt);
          errors++;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL or_done: done=%b pass=%b ready=%b, want 1 1 0",
               done, pass, in_ready);
      errors++;
    end
    checks++;
    if (vec_cnt !== 16'd16 || err_cnt !== 16'd0 || coverage !== 4'hF ||
        fail_valid !== 1'b0) begin
      $display("FAIL or_counts: vec=%0d err=%0d cov=%h fv=%b, want 16 0 f 0",
               vec_cnt, err_cnt, coverage, fail_valid);
      errors++;
    end
  endtask

  task automatic test_errors();
    // restart from DONE; results must clear at the following edge
    pulse_start(4'hE);
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || vec_cnt !== 16'd0 || coverage !== 4'h0) begin
      $display("FAIL restart_clear: done=%b pass=%b vec=%0d cov=%h, want 0 0 0 0",
               done, pass, vec_cnt, coverage);
      errors++;
    end
    in_valid = 1'b1;
    for (int v = 0; v < 16; v++) begin
      {in_a, in_b} = v[1:0];
      in_o         = v[1] | v[0];
      if (v == 2 || v == 7) in_o = 1'b0;  // vector 3 (10) and vector 8 (11)
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt !== 16'd2 || fail_valid !== 1'b1 || fail_idx !== 2'b10 ||
        fail_o !== 1'b0) begin
      $display("FAIL err_capture: err=%0d fv=%b idx=%b o=%b, want 2 1 10 0",
               err_cnt, fail_valid, fail_idx, fail_o);
      errors++;
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || vec_cnt !== 16'd16) begin
      $display("FAIL err_verdict: done=%b pass=%b vec=%0d, want 1 0 16",
               done, pass, vec_cnt);
      errors++;
    end
  endtask

  task automatic test_stop();
    pulse_start(4'hE);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    // stop together with a valid sample: the sample still counts
    stop     = 1'b1;
    in_valid = 1'b1;
    in_a     = 1'b0;
    in_b     = 1'b1;
    in_o     = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || vec_cnt !== 16'd3) begin
      $display("FAIL stop_done: done=%b ready=%b vec=%0d, want 1 0 3",
               done, in_ready, vec_cnt);
      errors++;
    end
    checks++;
    if (coverage !== 4'b0011 || pass !== 1'b0 || err_cnt !== 16'd0) begin
      $display("FAIL stop_result: cov=%b pass=%b err=%0d, want 0011 0 0",
               coverage, pass, err_cnt);
      errors++;
    end
    // valid held in DONE, plus a stray stop: nothing changes
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (vec_cnt !== 16'd3 || done !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL stop_hold: vec=%0d done=%b ready=%b, want 3 1 0",
               vec_cnt, done, in_ready);
      errors++;
    end
  endtask

  task automatic test_latch();
    pulse_start(4'hE);
    truth_tbl = 4'h8;                    // AND, must be ignored this run
    send(1'b0, 1'b1, 1'b1);
    checks++;
    if (err_cnt !== 16'd0 || fail_valid !== 1'b0 || vec_cnt !== 16'd1) begin
      $display("FAIL latch_tbl: err=%0d fv=%b vec=%0d, want 0 0 1",
               err_cnt, fail_valid, vec_cnt);
      errors++;
    end
    // start in RUN is ignored: counters keep going
    start = 1'b1;
    send(1'b1, 1'b0, 1'b0);              // mismatch under OR
    start = 1'b0;
    checks++;
    if (vec_cnt !== 16'd2 || err_cnt !== 16'd1 || fail_idx !== 2'b10 ||
        fail_o !== 1'b0 || fail_valid !== 1'b1) begin
      $display("FAIL start_in_run: vec=%0d err=%0d idx=%b o=%b fv=%b, want 2 1 10 0 1",
               vec_cnt, err_cnt, fail_idx, fail_o, fail_valid);
      errors++;
    end
    send(1'b1, 1'b1, 1'b0);              // second mismatch, capture must hold
    checks++;
    if (err_cnt !== 16'd2 || fail_idx !== 2'b10 || coverage !== 4'b1110) begin
      $display("FAIL first_fail_hold: err=%0d idx=%b cov=%b, want 2 10 1110",
               err_cnt, fail_idx, coverage);
      errors++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    truth_tbl = 4'hE;
  endtask

  task automatic test_back_to_back();
    int hs;
    logic v;
    hs = 0;
    pulse_start(4'hE);
    for (int c = 0; c < 400 && hs < 16; c++) begin
      v            = 1'($urandom_range(0, 1));
      in_valid     = v;
      {in_a, in_b} = hs[1:0];
      in_o         = hs[1] | hs[0];
      if (v) hs++;
      tick();
      checks++;
      if (vec_cnt !== CNT_W'(hs)) begin
        $display("FAIL rand_vec: cycle %0d vec=%0d, want %0d", c, vec_cnt, hs);
        errors++;
      end
    end
    checks++;
    if (hs < 16) begin
      $display("FAIL rand_timeout: handshakes=%0d, want 16", hs);
      errors++;
    end
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (vec_cnt !== 16'd16 || done !== 1'b1 || pass !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL rand_done_hold: vec=%0d done=%b pass=%b ready=%b, want 16 1 1 0",
               vec_cnt, done, pass, in_ready);
      errors++;
    end
    in_valid = 1'b0;
    pulse_start(4'hE);
    checks++;
    if (vec_cnt !== 16'd0 || err_cnt !== 16'd0 || coverage !== 4'h0 || done !== 1'b0 ||
        pass !== 1'b0 || fail_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL restart_all: vec=%0d err=%0d cov=%h done=%b pass=%b fv=%b ready=%b, want 0 0 0 0 0 0 1",
               vec_cnt, err_cnt, coverage, done, pass, fail_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_reset_midrun();
    // run already active from the previous task
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);              // the one error
    send(1'b1, 1'b1, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    checks++;
    if (vec_cnt !== 16'd5 || err_cnt !== 16'd1 || fail_valid !== 1'b1) begin
      $display("FAIL pre_reset: vec=%0d err=%0d fv=%b, want 5 1 1",
               vec_cnt, err_cnt, fail_valid);
      errors++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, done, pass, fail_valid, fail_idx, fail_o} !== 7'b0 ||
        vec_cnt !== 16'd0 || err_cnt !== 16'd0 || coverage !== 4'h0) begin
      $display("FAIL midrun_reset: flags=%b vec=%0d err=%0d cov=%h, want 0000000 0 0 0",
               {in_ready, done, pass, fail_valid, fail_idx, fail_o},
               vec_cnt, err_cnt, coverage);
      errors++;
    end
    in_valid = 1'b1;
    in_a     = 1'b1;
    in_b     = 1'b1;
    in_o     = 1'b0;
    stop     = 1'b1;
    tick();
    tick();
    stop     = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || vec_cnt !== 16'd0 || done !== 1'b0) begin
      $display("FAIL idle_ignore: ready=%b vec=%0d done=%b, want 0 0 0",
               in_ready, vec_cnt, done);
      errors++;
    end
    in_valid = 1'b0;
    pulse_start(4'h8);
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL post_reset_start: ready=%b, want 1", in_ready);
      errors++;
    end
    send(1'b1, 1'b1, 1'b1);              // AND table now in effect
    send(1'b0, 1'b1, 1'b1);              // mismatch under AND
    checks++;
    if (err_cnt !== 16'd1 || fail_idx !== 2'b01 || fail_o !== 1'b1) begin
      $display("FAIL and_run: err=%0d idx=%b o=%b, want 1 01 1",
               err_cnt, fail_idx, fail_o);
      errors++;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    truth_tbl = 4'h0;
    in_valid  = 1'b0;
    in_a      = 1'b0;
    in_b      = 1'b0;
    in_o      = 1'b0;
    test_reset();
    test_or_pass();
    test_errors();
    test_stop();
    test_latch();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
